hazard_stall_ctrl: RTL and testbench

- Pipeline stall controller for the 5-stage MIPS core.
- Holds a shadow scoreboard of the destination register and Tnew for the E and M stages, and a busy timer for the multiply/divide unit.
- From the D-stage instruction's Tuse and the pipeline state, generates `stall`. This freezes the PC (its stall input) and the F/D register.
- Generates `flush_E`, which inserts a bubble into the D/E register.

---
 rtl/hazard_stall_ctrl_pkg.sv | 50 +++++
 rtl/hazard_stall_ctrl_md_busy_timer.sv | 62 ++++++
 rtl/hazard_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl_pkg
//  Description : Shared widths, constants and helpers for the 5-stage MIPS
//                pipeline stall controller (hazard_stall_ctrl and its
//                md_busy_timer sub-module).
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    localparam int TUSE_W     = 2;
    localparam int TNEW_W     = 2;
    localparam int REG_ADDR_W = 5;
    localparam int MD_CNT_W   = 4;

    // A Tuse of 3 marks a source operand the instruction never reads.
    localparam logic [TUSE_W-1:0]     TUSE_NONE = 2'd3;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Shadow copy of an in-flight producer: destination GPR and remaining Tnew.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [TNEW_W-1:0]     tnew;
    } prod_slot_t;

    // Tnew as seen one stage later; saturates at zero instead of wrapping.
    function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // A source operand must wait if either tracked producer writes it and
    // will not have the value ready by the time the operand is consumed.
    function automatic logic src_hazard(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [TUSE_W-1:0]     tuse,
        input prod_slot_t            slot_e,
        input prod_slot_t            slot_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (addr == slot_e.dst) && (tuse < slot_e.tnew);
        hit_m = (addr == slot_m.dst) && (tuse < slot_m.tnew);
        return (addr != REG_ZERO) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : Occupancy tracker for the multiply/divide unit. Records
//                whether the instruction now in E starts an MD operation and
//                counts down the remaining busy cycles once it has left E.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                md_issue_i     - an MD start instruction enters E this edge
//                md_is_div_i    - that instruction is div/divu
//                md_busy_o      - MD unit occupied this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_issue_i,
    input  logic md_is_div_i,
    output logic md_busy_o
);

    // The counter is MD_CNT_W bits wide; cycle counts above 15 do not fit.
    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    logic                md_start_e_q, md_start_e_d;
    logic                md_div_e_q,   md_div_e_d;
    logic [MD_CNT_W-1:0] md_cnt_q,     md_cnt_d;

    always_comb begin
        md_start_e_d = md_issue_i;
        md_div_e_d   = md_issue_i & md_is_div_i;
        md_cnt_d     = md_cnt_q;
        // The countdown is loaded as the operation leaves E, so total
        // occupancy is one cycle in E plus the loaded count.
        if (md_start_e_q) begin
            md_cnt_d = md_div_e_q ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_start_e_q <= 1'b0;
            md_div_e_q   <= 1'b0;
            md_cnt_q     <= '0;
        end else begin
            md_start_e_q <= md_start_e_d;
            md_div_e_q   <= md_div_e_d;
            md_cnt_q     <= md_cnt_d;
        end
    end

    assign md_busy_o = md_start_e_q | (md_cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Stall controller for the 5-stage MIPS core. Keeps a shadow
//                scoreboard (destination GPR + Tnew) of the E and M stages and
//                the MD-unit busy state, and stalls the D-stage instruction
//                when an operand or the MD unit is not ready in time.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                instr_valid_D         - D holds a real instruction
//                rs/rt_addr_D          - source GPRs of the D instruction
//                tuse_rs/rt_D          - cycles until consumed (3 = unused)
//                dst_addr_D, tnew_D    - destination GPR and Tnew entering E
//                md_start_D/is_div_D   - mult/multu/div/divu in D
//                md_use_D              - mfhi/mflo/mthi/mtlo in D
//                stall                 - freeze PC and F/D register
//                flush_E               - load a bubble into D/E register
//                md_busy               - MD unit occupied
//                stat_data_stalls      - data-hazard stall cycles (option)
//                stat_md_stalls        - MD-hazard stall cycles   (option)
//  Options     : HAZARD_STALL_STATS_EN adds the two 32-bit stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid_D,
    input  logic [REG_ADDR_W-1:0] rs_addr_D,
    input  logic [REG_ADDR_W-1:0] rt_addr_D,
    input  logic [TUSE_W-1:0]     tuse_rs_D,
    input  logic [TUSE_W-1:0]     tuse_rt_D,
    input  logic [REG_ADDR_W-1:0] dst_addr_D,
    input  logic [TNEW_W-1:0]     tnew_D,
    input  logic                  md_start_D,
    input  logic                  md_is_div_D,
    input  logic                  md_use_D,
    output logic                  stall,
    output logic                  flush_E,
    output logic                  md_busy
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0]           stat_data_stalls,
    output logic [31:0]           stat_md_stalls
`endif
);

    prod_slot_t e_slot_q, e_slot_d;
    prod_slot_t m_slot_q, m_slot_d;

    logic rs_haz;
    logic rt_haz;
    logic data_haz;
    logic md_haz;
    logic issue;

    // ------------------------------------------------------------------
    // Hazard detection (purely combinational, same-cycle response)
    // ------------------------------------------------------------------
    assign rs_haz   = instr_valid_D & src_hazard(rs_addr_D, tuse_rs_D, e_slot_q, m_slot_q);
    assign rt_haz   = instr_valid_D & src_hazard(rt_addr_D, tuse_rt_D, e_slot_q, m_slot_q);
    assign data_haz = rs_haz | rt_haz;
    assign md_haz   = instr_valid_D & (md_start_D | md_use_D) & md_busy;

    assign stall   = data_haz | md_haz;
    assign flush_E = stall;

    // Only an instruction that actually leaves D is recorded in E.
    assign issue = instr_valid_D & ~stall;

    // ------------------------------------------------------------------
    // Scoreboard slot advance
    // ------------------------------------------------------------------
    always_comb begin
        e_slot_d = '0;
        if (issue) begin
            e_slot_d.dst  = dst_addr_D;
            e_slot_d.tnew = tnew_D;
        end
        m_slot_d.dst  = e_slot_q.dst;
        m_slot_d.tnew = tnew_age(e_slot_q.tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_slot_q <= '0;
            m_slot_q <= '0;
        end else begin
            e_slot_q <= e_slot_d;
            m_slot_q <= m_slot_d;
        end
    end

    // ------------------------------------------------------------------
    // Multiply/divide occupancy
    // ------------------------------------------------------------------
    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk         (clk),
        .reset       (reset),
        .md_issue_i  (issue & md_start_D),
        .md_is_div_i (md_is_div_D),
        .md_busy_o   (md_busy)
    );

`ifdef HAZARD_STALL_STATS_EN
    // ------------------------------------------------------------------
    // Stall statistics; a cycle with both causes counts in both.
    // ------------------------------------------------------------------
    logic [31:0] stat_data_q, stat_data_d;
    logic [31:0] stat_md_q,   stat_md_d;

    always_comb begin
        stat_data_d = stat_data_q + {31'd0, data_haz};
        stat_md_d   = stat_md_q   + {31'd0, md_haz};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_data_q <= '0;
            stat_md_q   <= '0;
        end else begin
            stat_data_q <= stat_data_d;
            stat_md_q   <= stat_md_d;
        end
    end

    assign stat_data_stalls = stat_data_q;
    assign stat_md_stalls   = stat_md_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl. A driver feeds an
//                instruction stream into D (holding an instruction while the
//                reference model says it stalls), pushes the model's expected
//                stall/md_busy into a scoreboard, and a monitor compares on
//                the falling edge. HAZARD_STALL_STATS_EN enables stat checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_D;
    logic [4:0]  rs_addr_D, rt_addr_D, dst_addr_D;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_D;
    logic        md_start_D, md_is_div_D, md_use_D;
    logic        stall, flush_E, md_busy;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stat_data_stalls, stat_md_stalls;
`endif

    hazard_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid_D    (instr_valid_D),
        .rs_addr_D        (rs_addr_D),
        .rt_addr_D        (rt_addr_D),
        .tuse_rs_D        (tuse_rs_D),
        .tuse_rt_D        (tuse_rt_D),
        .dst_addr_D       (dst_addr_D),
        .tnew_D           (tnew_D),
        .md_start_D       (md_start_D),
        .md_is_div_D      (md_is_div_D),
        .md_use_D         (md_use_D),
        .stall            (stall),
        .flush_E          (flush_E),
        .md_busy          (md_busy)
`ifdef HAZARD_STALL_STATS_EN
        ,
        .stat_data_stalls (stat_data_stalls),
        .stat_md_stalls   (stat_md_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit [4:0] rs;
        bit [1:0] tuse_rs;
        bit [4:0] rt;
        bit [1:0] tuse_rt;
        bit [4:0] dst;
        bit [1:0] tnew;
        bit       md_start;
        bit       md_div;
        bit       md_use;
    } instr_t;

    typedef struct { int cyc; bit stall; bit busy; } exp_t;
    typedef struct { int cyc; bit [4:0] dst; int tnew; } issued_t;

    instr_t  iq[$];       // instruction stream waiting to enter/leave D
    exp_t    sb[$];       // scoreboard of expected per-cycle responses
    issued_t issued[$];   // instructions that left D, stamped with issue cycle

    int cyc           = 0;
    int md_until      = -1;  // last cycle the MD unit is occupied
    int n_checks      = 0;
    int n_fail        = 0;
    int dut_stall_cnt = 0;
    int m_data_cnt    = 0;
    int m_md_cnt      = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input bit v, input int rs, input int tur, input int rt,
                                  input int tut, input int dst, input int tn,
                                  input bit ms, input bit md, input bit mu);
        instr_t i;
        i.valid = v;  i.rs = 5'(rs); i.tuse_rs = 2'(tur); i.rt = 5'(rt); i.tuse_rt = 2'(tut);
        i.dst = 5'(dst); i.tnew = 2'(tn); i.md_start = ms; i.md_div = md; i.md_use = mu;
        return i;
    endfunction

    function automatic instr_t bubble();
        return mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
    endfunction

    // Reference: a producer issued `age` cycles ago has Tnew reduced by one
    // per stage passed beyond E; only E (age 1) and M (age 2) are tracked.
    function automatic bit data_hazard(input instr_t d);
        int age, rem;
        if (!d.valid) return 1'b0;
        foreach (issued[i]) begin
            age = cyc - issued[i].cyc;
            if (age < 1 || age > 2) continue;
            rem = issued[i].tnew - (age - 1);
            if (rem < 0) rem = 0;
            if (d.rs != 0 && d.rs == issued[i].dst && int'(d.tuse_rs) < rem) return 1'b1;
            if (d.rt != 0 && d.rt == issued[i].dst && int'(d.tuse_rt) < rem) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_busy();
        return cyc <= md_until;
    endfunction

    task automatic drive(input instr_t d);
        instr_valid_D = d.valid;
        rs_addr_D     = d.rs;
        rt_addr_D     = d.rt;
        tuse_rs_D     = d.tuse_rs;
        tuse_rt_D     = d.tuse_rt;
        dst_addr_D    = d.dst;
        tnew_D        = d.tnew;
        md_start_D    = d.md_start;
        md_is_div_D   = d.md_div;
        md_use_D      = d.md_use;
    endtask

    // One clock cycle: present head of stream, predict, then advance model.
    task automatic tick();
        instr_t d;
        bit     dh, mh, st;
        d  = (iq.size() != 0) ? iq[0] : bubble();
        drive(d);
        dh = data_hazard(d);
        mh = d.valid && (d.md_start || d.md_use) && model_busy();
        st = dh || mh;
        sb.push_back('{cyc, st, model_busy()});
        if (dh) m_data_cnt++;
        if (mh) m_md_cnt++;
        @(posedge clk);
        if (!st) begin
            if (iq.size() != 0) void'(iq.pop_front());
            if (d.valid) begin
                issued.push_back('{cyc, d.dst, int'(d.tnew)});
                if (d.md_start) md_until = cyc + 1 + (d.md_div ? DIV_N : MULT_N);
            end
        end
        cyc++;
        while (issued.size() != 0 && cyc - issued[0].cyc > 2) void'(issued.pop_front());
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive((iq.size() != 0) ? iq[0] : bubble());
        @(posedge clk);
        #1;
        reset = 1'b0;
        issued.delete();
        md_until   = -1;
        m_data_cnt = 0;
        m_md_cnt   = 0;
    endtask

    // Drain the stream, idle until the pipeline is empty, and compare the
    // number of stall cycles the DUT showed against the expected count.
    task automatic run_seq(input string name, input int exp_stalls);
        int base, guard;
        base  = dut_stall_cnt;
        guard = 0;
        while (iq.size() != 0 && guard < 8000) begin
            tick();
            guard++;
        end
        if (iq.size() != 0) begin
            check({name, "_timeout"}, iq.size(), 0);
            iq.delete();
        end
        repeat (12) tick();
        if (exp_stalls >= 0) check({name, "_stalls"}, dut_stall_cnt - base, exp_stalls);
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check($sformatf("stall@%0d", mon_e.cyc),   stall,   mon_e.stall);
            check($sformatf("flush_E@%0d", mon_e.cyc), flush_E, mon_e.stall);
            check($sformatf("md_busy@%0d", mon_e.cyc), md_busy, mon_e.busy);
            if (stall) dut_stall_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t lw1, lw0, add1, addrt, beq1, add0, mult, divi, mflo, r;

        lw1   = mk(1, 0, 3, 0, 3, 1, 2, 0, 0, 0);
        lw0   = mk(1, 0, 3, 0, 3, 0, 2, 0, 0, 0);
        add1  = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        addrt = mk(1, 2, 1, 1, 1, 3, 1, 0, 0, 0);
        beq1  = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        add0  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        mult  = mk(1, 4, 1, 5, 1, 0, 0, 1, 0, 0);
        divi  = mk(1, 4, 1, 5, 1, 0, 0, 1, 1, 0);
        mflo  = mk(1, 0, 3, 0, 3, 6, 1, 0, 0, 1);

        drive(bubble());
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_md_busy", md_busy, 0);
        check("reset_stall",   stall,   0);
        check("reset_flush_E", flush_E, 0);
`ifdef HAZARD_STALL_STATS_EN
        check("reset_stat_data", stat_data_stalls, 0);
        check("reset_stat_md",   stat_md_stalls,   0);
`endif

        iq = '{lw1, add1};   run_seq("load_use_alu_rs", 1);
        iq = '{lw1, addrt};  run_seq("load_use_alu_rt", 1);
        iq = '{lw1, beq1};   run_seq("load_use_branch", 2);
        iq = '{lw0, add0};   run_seq("zero_reg", 0);
        iq = '{mult, mflo};  run_seq("mult_mflo", 6);
        iq = '{divi, mflo};  run_seq("div_mflo", 11);

        // Reset while the divide is in its fourth cycle; mflo waits in D.
        iq = '{divi, mflo};
        repeat (4) tick();
        do_reset();
        run_seq("reset_mid_div", 0);

`ifdef HAZARD_STALL_STATS_EN
        do_reset();
        iq = '{lw1, add1, mult, mflo};
        run_seq("stats_seq", 7);
        check("stat_data_stalls", stat_data_stalls, 1);
        check("stat_md_stalls",   stat_md_stalls,   6);
`endif

        // Randomized stream with a small register set to provoke hazards.
        do_reset();
        repeat (500) begin
            r = mk($urandom_range(7, 0) != 0,
                   $urandom_range(3, 0), $urandom_range(3, 0),
                   $urandom_range(3, 0), $urandom_range(3, 0),
                   $urandom_range(3, 0), $urandom_range(2, 0),
                   $urandom_range(9, 0) == 0, $urandom_range(1, 0) == 1,
                   $urandom_range(5, 0) == 0);
            if (r.md_start) r.md_use = 1'b0;
            iq.push_back(r);
        end
        run_seq("random", -1);
`ifdef HAZARD_STALL_STATS_EN
        check("stat_data_random", stat_data_stalls, m_data_cnt);
        check("stat_md_random",   stat_md_stalls,   m_md_cnt);
        do_reset();
        check("stat_data_cleared", stat_data_stalls, 0);
        check("stat_md_cleared",   stat_md_stalls,   0);
`endif

        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
